// File: rtl/i2s_rx_if.sv
// i2s_rx_if -- bundle of the I2S pins and the frame hand-off signals.
//   sck/lrck/sd : serial bit clock, word select and data from the I2S source
//   ack         : consumer acknowledge of the presented frame
//   sound       : last complete frame, left in the upper WORD bits
//   valid       : sound holds a frame not yet acknowledged
//   overrun     : sticky, an unacknowledged frame was replaced
//   synced      : frame alignment acquired
// master = receiver side (drives the frame outputs), slave = source/consumer side.
`timescale 1ns/1ps
interface i2s_rx_if #(
  parameter int WORD = 16
);
  logic              sck;
  logic              lrck;
  logic              sd;
  logic              ack;
  logic [2*WORD-1:0] sound;
  logic              valid;
  logic              overrun;
  logic              synced;

  modport master (
    input  sck, lrck, sd, ack,
    output sound, valid, overrun, synced
  );

  modport slave (
    output sck, lrck, sd, ack,
    input  sound, valid, overrun, synced
  );
endinterface

// File: rtl/i2s_rx.sv
// i2s_rx -- I2S serial receiver in the system-clock domain.
// The external sck/lrck/sd are synchronized, sck rising edges are detected,
// and an ALIGN/LEFT/RIGHT FSM assembles MSB-first words of WORD bits per
// channel (zero-filled if short, extra bits dropped). A frame completes on
// the lrck fall that ends the right channel and is presented with a
// valid/ack hand-off; replacing an unacknowledged frame sets sticky overrun.
// Ports:
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   bus     : i2s_rx_if.master (sck, lrck, sd, ack in; sound, valid, overrun, synced out)
`timescale 1ns/1ps
module i2s_rx #(
  parameter int WORD = 16
) (
  input logic      clk,
  input logic      reset_n,
  i2s_rx_if.master bus
);

  localparam int CW = $clog2(WORD + 1);

  typedef enum logic [1:0] {ALIGN, LEFT, RIGHT} state_e;

  state_e            state_q, state_d;
  logic [1:0]        sck_sync_q, lrck_sync_q, sd_sync_q;
  logic              sck_prev_q;
  logic              lrck_prev_q, lrck_prev_d;
  logic [WORD-1:0]   shift_q, shift_d;
  logic [WORD-1:0]   left_q, left_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*WORD-1:0] sound_q, sound_d;
  logic              valid_q, valid_d;
  logic              overrun_q, overrun_d;
  logic              sck_rise, lrck_s, sd_s, lr_fall, lr_rise, frame_done;

  // Two-flop synchronizers; sck_prev_q is one more stage for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sck_sync_q  <= '0;
      lrck_sync_q <= '0;
      sd_sync_q   <= '0;
      sck_prev_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      sck_sync_q  <= {sck_sync_q[0], bus.sck};
      lrck_sync_q <= {lrck_sync_q[0], bus.lrck};
      sd_sync_q   <= {sd_sync_q[0], bus.sd};
      sck_prev_q  <= sck_sync_q[1];
    end
  end

  // lrck and sd travel through the same depth as sck, so they are
  // coherent with the detected edge.
  assign sck_rise = sck_sync_q[1] & ~sck_prev_q;
  assign lrck_s   = lrck_sync_q[1];
  assign sd_s     = sd_sync_q[1];
  assign lr_fall  = sck_rise & lrck_prev_q & ~lrck_s;
  assign lr_rise  = sck_rise & ~lrck_prev_q & lrck_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ALIGN;
    else          state_q <= state_d;
  end

  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned (no latches).
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    left_d      = left_q;
    lrck_prev_d = lrck_prev_q;
    frame_done  = 1'b0;
    sound_d     = sound_q;
    valid_d     = valid_q;
    overrun_d   = overrun_q;

    if (sck_rise) begin
      lrck_prev_d = lrck_s;
      case (state_q)
        ALIGN: begin
          if (lr_fall) begin
            state_d = LEFT;
            shift_d = '0;
            cnt_d   = '0;
          end
        end
        LEFT: begin
          if (lr_rise) begin
            // Delay slot of the right channel: commit left, drop this sd.
            left_d  = shift_q;
            state_d = RIGHT;
            shift_d = '0;
            cnt_d   = '0;
          end else if (cnt_q < CW'(WORD)) begin
            // Place the bit at its final position so short words zero-fill.
            shift_d = shift_q | (WORD'(sd_s) << (CW'(WORD - 1) - cnt_q));
            cnt_d   = cnt_q + CW'(1);
          end
        end
        RIGHT: begin
          if (lr_fall) begin
            frame_done = 1'b1;
            state_d    = LEFT;
            shift_d    = '0;
            cnt_d      = '0;
          end else if (cnt_q < CW'(WORD)) begin
            shift_d = shift_q | (WORD'(sd_s) << (CW'(WORD - 1) - cnt_q));
            cnt_d   = cnt_q + CW'(1);
          end
        end
        default: state_d = ALIGN;
      endcase
    end

    // A completing frame wins over ack; overrun only if nobody took the old one.
    if (frame_done) begin
      sound_d = {left_q, shift_q};
      valid_d = 1'b1;
      if (valid_q && !bus.ack) overrun_d = 1'b1;
    end else if (bus.ack) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the shift register and word holder are reset too, so a reset
      // mid-frame cannot leak stale bits into the next frame.
      shift_q     <= '0;
      left_q      <= '0;
      cnt_q       <= '0;
      lrck_prev_q <= 1'b0;
      sound_q     <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      shift_q     <= shift_d;
      left_q      <= left_d;
      cnt_q       <= cnt_d;
      lrck_prev_q <= lrck_prev_d;
      sound_q     <= sound_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.sound   = sound_q;
  assign bus.valid   = valid_q;
  assign bus.overrun = overrun_q;
  assign bus.synced  = (state_q != ALIGN);

endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx -- directed bench for i2s_rx (WORD=16, sck = clk/8).
`timescale 1ns/1ps
module tb_i2s_rx;
  localparam int WORD = 16;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  i2s_rx_if #(.WORD(WORD)) bus ();

  i2s_rx #(.WORD(WORD)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  always #5 clk = ~clk;

  int          pass_cnt  = 0;
  int          total_cnt = 0;
  int          vcnt      = 0;
  int          base;
  logic [31:0] last_sound = '0;
  time         rise_t = 0;
  time         valid_t = 0;

  // Every clk cycle with valid high is counted; with ack tied 1 that is
  // exactly one per reported frame.
  always @(negedge clk) begin
    if (bus.valid) begin
      vcnt++;
      last_sound = bus.sound;
    end
  end

  always @(posedge bus.valid) valid_t = $time;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // One sck period: data changes while sck is low, receiver samples on the rise.
  task automatic send_bit(input logic lr, input logic d);
    bus.sck  = 1'b0;
    bus.lrck = lr;
    bus.sd   = d;
    #40;
    bus.sck = 1'b1;
    rise_t  = $time;
    #40;
  endtask

  task automatic send_data(input logic lr, input logic [31:0] data, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(lr, data[i]);
  endtask

  // Left bits, right delay slot, right bits, then the lrck fall that commits.
  // Delay slots carry sd=1 so a receiver that keeps them gets a wrong word.
  task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int n);
    send_data(1'b0, l, n);
    send_bit(1'b1, 1'b1);
    send_data(1'b1, r, n);
    send_bit(1'b0, 1'b1);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.sck  = 1'b0;
    bus.lrck = 1'b0;
    bus.sd   = 1'b0;
    bus.ack  = 1'b1;
    #22;
    check("rst_sound",   bus.sound,            32'h0);
    check("rst_valid",   32'(bus.valid),       32'h0);
    check("rst_overrun", 32'(bus.overrun),     32'h0);
    check("rst_synced",  32'(bus.synced),      32'h0);
    reset_n = 1'b1;
    #8;

    // Stream joins mid right channel: nothing reported, no alignment yet.
    send_data(1'b1, 32'h0000_002D, 6);
    check("align_synced",  32'(bus.synced), 32'h0);
    check("align_novalid", 32'(vcnt),       32'h0);
    send_bit(1'b0, 1'b1);
    check("synced_fall",   32'(bus.synced), 32'h1);

    // ack tied 1: each frame gives a single-cycle valid pulse.
    send_frame(32'hA5C3, 32'h0F81, 16);
    check("f1_count",   32'(vcnt),       32'd1);
    check("f1_sound",   last_sound,      32'hA5C3_0F81);
    check("f1_latency", 32'(valid_t >= rise_t && (valid_t - rise_t) <= 40), 32'h1);
    check("f1_valid",   32'(bus.valid),  32'h0);
    check("f1_overrun", 32'(bus.overrun), 32'h0);

    send_frame(32'h1357, 32'h8000, 16);
    check("f2_count", 32'(vcnt),  32'd2);
    check("f2_sound", last_sound, 32'h1357_8000);

    // 24 bits per channel: the extra 8 LSBs are dropped.
    send_frame(32'h123456, 32'hABCDEF, 24);
    check("long_count", 32'(vcnt),  32'd3);
    check("long_sound", last_sound, 32'h1234_ABCD);

    // 8 bits per channel: missing LSBs read as zero.
    send_frame(32'hFF, 32'h81, 8);
    check("short_count",   32'(vcnt),        32'd4);
    check("short_sound",   last_sound,       32'hFF00_8100);
    check("short_overrun", 32'(bus.overrun), 32'h0);

    // ack held 0 across two frames.
    @(negedge clk);
    bus.ack = 1'b0;
    send_frame(32'hDEAD, 32'hBEEF, 16);
    check("hold1_valid",   32'(bus.valid),   32'h1);
    check("hold1_sound",   bus.sound,        32'hDEAD_BEEF);
    check("hold1_overrun", 32'(bus.overrun), 32'h0);
    send_frame(32'h0123, 32'h4567, 16);
    check("hold2_valid",   32'(bus.valid),   32'h1);
    check("hold2_sound",   bus.sound,        32'h0123_4567);
    check("hold2_overrun", 32'(bus.overrun), 32'h1);
    @(negedge clk);
    bus.ack = 1'b1;
    @(negedge clk);
    bus.ack = 1'b0;
    @(negedge clk);
    check("ack_valid",   32'(bus.valid),   32'h0);
    check("ack_overrun", 32'(bus.overrun), 32'h1);
    check("ack_sound",   bus.sound,        32'h0123_4567);

    // Leave a frame pending, then reset in the middle of the next left word.
    send_frame(32'h5555, 32'hAAAA, 16);
    check("pre_rst_valid", 32'(bus.valid), 32'h1);
    check("pre_rst_sound", bus.sound,      32'h5555_AAAA);
    send_data(1'b0, 32'h0000_FFFF, 5);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_sound",   bus.sound,        32'h0);
    check("arst_valid",   32'(bus.valid),   32'h0);
    check("arst_overrun", 32'(bus.overrun), 32'h0);
    check("arst_synced",  32'(bus.synced),  32'h0);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    bus.ack = 1'b1;
    base    = vcnt;

    // Rest of the broken frame must not be reported; the fall realigns.
    send_data(1'b0, 32'h0, 11);
    send_bit(1'b1, 1'b1);
    send_data(1'b1, 32'hFFFF, 16);
    send_bit(1'b0, 1'b1);
    repeat (4) @(negedge clk);
    check("realign_novalid", 32'(vcnt - base), 32'd0);
    check("realign_synced",  32'(bus.synced),  32'h1);

    send_frame(32'h3C3C, 32'hC3C5, 16);
    check("post_rst_count",   32'(vcnt - base),  32'd1);
    check("post_rst_sound",   last_sound,        32'h3C3C_C3C5);
    check("post_rst_overrun", 32'(bus.overrun),  32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/i2s_rx.md
I2S_RX -- requirements
Module: i2s_rx

Interface
REQ-001 Parameter: WORD, default 16, bits captured per channel (1..32).
REQ-002 Port: clk  input  1  system clock (24.576 MHz class, from PLL).
REQ-003 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 Port: sck  input  1  external I2S bit clock, asynchronous to clk.
REQ-005 Port: lrck  input  1  external I2S word select (low = left, high = right), asynchronous to clk.
REQ-006 Port: sd  input  1  external I2S serial data, MSB first, asynchronous to clk.
REQ-007 Port: sound  output  2*WORD  last complete frame: left in [2*WORD-1:WORD], right in [WORD-1:0].
REQ-008 Port: valid  output  1  high while sound holds a frame not yet acknowledged.
REQ-009 Port: ack  input  1  consumer acknowledge, sampled on rising clk.
REQ-010 Port: overrun  output  1  sticky; a frame replaced an unacknowledged frame.
REQ-011 Port: synced  output  1  high once frame alignment has been acquired.

Function
REQ-012 sck, lrck and sd SHALL each pass through a 2-flop synchronizer in the clk domain before use.
REQ-013 An sck rising edge SHALL be detected on the clk cycle where synchronized sck is 1 and its previous value was 0; all serial sampling SHALL occur only on detected edges.
REQ-014 Correct operation SHALL be required only when sck high and low phases each last at least 2 clk periods.
REQ-015 At each detected sck edge, the block SHALL sample lrck and sd together and compare lrck with the lrck value from the previous detected edge.
REQ-016 The FSM SHALL have three states: ALIGN, LEFT and RIGHT.
REQ-017 In ALIGN, the FSM SHALL ignore sd and go to LEFT on the first lrck 1->0 change.
REQ-018 From LEFT, an lrck 0->1 change SHALL commit the left word and move to RIGHT.
REQ-019 From RIGHT, an lrck 1->0 change SHALL commit the right word, complete the frame and move to LEFT.
REQ-020 The edge where the lrck change is seen is the I2S delay slot; its sd value SHALL be discarded.
REQ-021 The first data bit SHALL be sampled on the next edge and treated as the MSB.
REQ-022 Per channel, the first WORD sd samples after the delay slot SHALL be shifted in MSB first; further samples SHALL be ignored.
REQ-023 If a channel ends after fewer than WORD samples, the unfilled LSBs SHALL be 0.
REQ-024 The per-channel bit counter SHALL saturate at WORD and SHALL NOT wrap.
REQ-025 On frame completion, sound SHALL update and valid SHALL go to 1 on the clk cycle after the detecting edge cycle.
REQ-026 Latency from a physical sck rise to the valid assertion SHALL be at most 4 clk.
REQ-027 valid SHALL remain 1 and sound SHALL remain stable until ack is sampled 1.
REQ-028 When ack is sampled 1, valid SHALL go to 0 on the next cycle.
REQ-029 If ack is 0 when a frame completes while valid=1, sound SHALL take the new frame, valid SHALL stay 1, and overrun SHALL go to 1.
REQ-030 If ack is 1 in the same cycle a frame completes, the new frame SHALL load, valid SHALL stay 1, and overrun SHALL be unaffected.
REQ-031 When ack is 1 while valid=0, ack SHALL have no effect.
REQ-032 overrun SHALL clear only on reset.
REQ-033 synced SHALL be 1 in LEFT and RIGHT and 0 in ALIGN.

Reset
REQ-034 While reset_n=0, the block SHALL force: sound=0, valid=0, overrun=0, synced=0, FSM=ALIGN, shift registers, bit counters and synchronizers=0.
REQ-035 Reset assertion SHALL take effect immediately, without waiting for clk.
REQ-036 Reset asserted mid-frame SHALL discard the partial frame; after release the block SHALL realign via ALIGN.
REQ-037 After reset release, the first commit SHALL require a full lrck low period, then a high period, then the next 1->0 change.

Verification
REQ-038 Scenario: sck = clk/8, WORD=16, left 0xA5C3, right 0x0F81, ack tied 1 -> sound=0xA5C30F81; valid pulses one cycle per frame; overrun stays 0.
REQ-039 Scenario: stream starts mid right channel -> that first partial frame is not reported; synced=1 after the first lrck fall; the first valid frame is correct.
REQ-040 Scenario: 24 bits per channel, left 0x123456, right 0xABCDEF -> sound=0x1234ABCD.
REQ-041 Scenario: 8 bits per channel, left 0xFF, right 0x81 -> sound=0xFF008100.
REQ-042 Scenario: ack held 0 over two frames F1, F2 -> after F2, sound=F2, valid=1, overrun=1; a later ack clears valid only.
REQ-043 Scenario: reset_n pulsed low for 1 clk mid left word -> all outputs go to 0 asynchronously; no frame is reported until realignment; the next full frame is correct.
